activation_layer: RTL and testbench
===================================

ACTIVATION_LAYER -- requirements
Module: activation_layer

Interface
REQ-001 Parameter WIDTH, 10: width of each signed fixed-point sample.
REQ-002 Parameter NFRAC, 5: fractional bits per sample; must satisfy 0 < NFRAC < WIDTH.
REQ-003 Parameter SIZE, 32: number of parallel lanes.
REQ-004 Parameter MEM_WIDTH, 10: bits per table entry, all fractional, unsigned.
REQ-005 Parameter TABLE_SIZE_POW, 10: log2 of the table depth; TABLE_SIZE = 2**TABLE_SIZE_POW.
REQ-006 Parameter BRAM_FILE, "memw10_size1024_sigmoidBRAM.mem": binary table image, loaded once at elaboration.
REQ-007 clk  input  1  single clock; all registers update on its rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 input_data  input  signed [WIDTH-1:0] x SIZE  one sample per lane.
REQ-010 output_data  output  signed [WIDTH-1:0] x SIZE  sigmoid(input) per lane, in the same Q format.

Function
REQ-011 Each lane SHALL compute sigmoid independently using one read of a TABLE_SIZE-entry ROM. Entry k holds sigmoid(16*(k - TABLE_SIZE/2)/TABLE_SIZE), covering the range -8 to +8.
REQ-012 Index arithmetic SHALL be signed and at least WIDTH+TABLE_SIZE_POW+2 bits wide, with no overflow: scaled = X * 2**TABLE_SIZE_POW / 16, where X is the raw input integer.
REQ-013 The index SHALL be computed as idx = floor(scaled / 2**NFRAC) + TABLE_SIZE/2, using an arithmetic shift.
REQ-014 Clamp: idx < 0 -> 0; idx > TABLE_SIZE-1 -> TABLE_SIZE-1; otherwise idx is used unchanged.
REQ-015 Stage 1: the clamped index SHALL be registered on each rising edge of clk.
REQ-016 Stage 2: the ROM entry addressed by the stage-1 register SHALL be registered into the output.
REQ-017 Latency SHALL be 2 cycles: input sampled at edge N appears on output_data after edge N+1 and is held until edge N+2.
REQ-018 The pipeline SHALL be fully pipelined, with a new input accepted every cycle and no handshake.
REQ-019 Output alignment from a table entry E:
- MEM_WIDTH == NFRAC: output = E, zero-extended.
- MEM_WIDTH < NFRAC: output = E << (NFRAC-MEM_WIDTH).
- MEM_WIDTH > NFRAC: output = E >> (MEM_WIDTH-NFRAC).
REQ-020 Output integer and sign bits SHALL always be 0, so the output lies in [0, 1).

Reset
REQ-021 While reset is low, all stage-1 index registers and all output_data lanes SHALL be 0, asynchronously, regardless of clk.
REQ-022 After reset goes high, the first valid output SHALL appear after the second rising edge.
REQ-023 Reset asserted mid-stream SHALL immediately zero both stages, and in-flight samples are discarded.
REQ-024 Reset SHALL NOT affect the ROM contents.

Configuration
REQ-025 Macro ACTIVATION_LAYER_ROUND_EN:
- Defined: idx SHALL be computed as floor((scaled + 2**(NFRAC-1)) / 2**NFRAC) + TABLE_SIZE/2, i.e. round to nearest with ties toward +inf.
- Not defined: the truncating floor of REQ-013 SHALL be used.
- Clamping and latency are identical in both builds.

Verification
All scenarios use WIDTH=16, NFRAC=12, SIZE=8, MEM_WIDTH=10, TABLE_SIZE_POW=10, with a table file whose entry 512 = 512 (0.5).

REQ-026 Reset low with arbitrary inputs -> all lanes 0x0000; reset released with lanes 0x0000..0x0007 -> lanes show 0x0800 two edges later (index 512 for all; also 512 with ROUND_EN).

REQ-027 Input 0x1000 (+1.0) -> index 576 -> output table[576] << 2.
- Input 0xF000 (-1.0) -> index 448 -> output table[448] << 2.

REQ-028 Saturation:
- Input 0x8000 (-8.0) -> index 0 -> output table[0] << 2.
- Input 0x7FFF -> index 1023 -> output table[1023] << 2.
- An oversized negative scale maps to index 0 with no wrap-around.

REQ-029 Back-to-back distinct inputs on consecutive cycles -> outputs appear in the same order, each exactly 2 cycles later, with no bubbles.

REQ-030 Rounding, input 0x0020 (scaled = 2048):
- Without macro: index 512.
- With ACTIVATION_LAYER_ROUND_EN: index 513.

REQ-031 Reset pulsed low for less than one clock period mid-stream -> outputs go to 0 immediately.
- Valid data resumes 2 edges after reset is released.

Source files
------------

// File: rtl/activation_layer.sv
// activation_layer: per-lane sigmoid by clamped table lookup, index register then output register.
// Define ACTIVATION_LAYER_ROUND_EN to round the table index to nearest (ties toward +inf) instead of flooring.
module activation_layer #(
  parameter int WIDTH          = 10,
  parameter int NFRAC          = 5,
  parameter int SIZE           = 32,
  parameter int MEM_WIDTH      = 10,
  parameter int TABLE_SIZE_POW = 10,
  parameter     BRAM_FILE      = "memw10_size1024_sigmoidBRAM.mem"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] input_data  [SIZE],
  output logic signed [WIDTH-1:0] output_data [SIZE]
);

  localparam int TABLE_SIZE = 2 ** TABLE_SIZE_POW;
  localparam int IW         = WIDTH + TABLE_SIZE_POW + 2;
  localparam int ALIGN_DOWN = (MEM_WIDTH > NFRAC) ? (MEM_WIDTH - NFRAC) : 0;
  localparam int ALIGN_UP   = (NFRAC > MEM_WIDTH) ? (NFRAC - MEM_WIDTH) : 0;

  localparam logic signed [IW-1:0] HALF_TABLE = IW'(TABLE_SIZE / 2);
  localparam logic signed [IW-1:0] TOP_INDEX  = IW'(TABLE_SIZE - 1);

  if (NFRAC <= 0 || NFRAC >= WIDTH || TABLE_SIZE_POW > 30 || $bits(BRAM_FILE) == 0) begin : g_bad_config
    $error("activation_layer: unsupported parameter combination");
  end

  // Table entry k = round(sigmoid(16*(k - TABLE_SIZE/2)/TABLE_SIZE) * 2**MEM_WIDTH), saturated.
  // Evaluated at elaboration in Q30 fixed point so it reproduces the BRAM_FILE image without a file.
  function automatic logic [MEM_WIDTH-1:0] table_entry(input int k);
    longint one;
    longint d;
    longint y;
    longint term;
    longint ex;
    longint sig;
    longint ent;
    longint full;
    one  = longint'(1) <<< 30;
    d    = longint'(k) - longint'(TABLE_SIZE / 2);
    y    = ((d < 0) ? -d : d) <<< (30 - TABLE_SIZE_POW);
    term = one;
    ex   = one;
    for (int n = 1; n < 16; n++) begin
      term = ((term * y) >>> 30) / longint'(n);
      ex   = (n % 2 == 1) ? (ex - term) : (ex + term);
    end
    for (int s = 0; s < 4; s++) begin
      ex = (ex * ex) >>> 30;
    end
    if (d < 0) begin
      sig = (ex <<< 30) / (one + ex);
    end else begin
      sig = (one <<< 30) / (one + ex);
    end
    ent  = ((sig <<< MEM_WIDTH) + (one >>> 1)) >>> 30;
    full = (longint'(1) <<< MEM_WIDTH) - 1;
    if (ent > full) begin
      ent = full;
    end
    return MEM_WIDTH'(ent);
  endfunction

  logic [MEM_WIDTH-1:0] rom [TABLE_SIZE];

  for (genvar k = 0; k < TABLE_SIZE; k++) begin : g_rom
    localparam logic [MEM_WIDTH-1:0] ENTRY = table_entry(k);
    assign rom[k] = ENTRY;
  end

  // The index width leaves room for the full input range times 2**TABLE_SIZE_POW, so nothing wraps before the clamp.
  function automatic logic [TABLE_SIZE_POW-1:0] compute_index(input logic signed [WIDTH-1:0] x);
    logic signed [IW-1:0] scaled;
    logic signed [IW-1:0] idx;
    logic [TABLE_SIZE_POW-1:0] result;
    scaled = IW'(x);
    scaled = (scaled <<< TABLE_SIZE_POW) >>> 4;
`ifdef ACTIVATION_LAYER_ROUND_EN
    scaled = scaled + IW'(2 ** (NFRAC - 1));
`else
    scaled = scaled;
`endif
    idx = (scaled >>> NFRAC) + HALF_TABLE;
    if (idx[IW-1]) begin
      result = '0;
    end else if (idx > TOP_INDEX) begin
      result = '1;
    end else begin
      result = idx[TABLE_SIZE_POW-1:0];
    end
    return result;
  endfunction

  logic [TABLE_SIZE_POW-1:0] idx_next [SIZE];
  logic [TABLE_SIZE_POW-1:0] idx_q    [SIZE];

  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      idx_next[i] = compute_index(input_data[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SIZE; i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        idx_q[i] <= idx_next[i];
      end
    end
  end

  // Table entries are pure fractions; aligning them to NFRAC keeps the integer and sign bits at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SIZE; i++) begin
        output_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        output_data[i] <= signed'((WIDTH'(rom[idx_q[i]] >> ALIGN_DOWN)) << ALIGN_UP);
      end
    end
  end

endmodule

// File: tb/tb_activation_layer.sv
// tb_activation_layer: directed checks of reset, lookup, saturation, rounding, streaming and mid-stream reset.
module tb_activation_layer;

  localparam int WIDTH          = 16;
  localparam int NFRAC          = 12;
  localparam int SIZE           = 8;
  localparam int MEM_WIDTH      = 10;
  localparam int TABLE_SIZE_POW = 10;

  logic clk = 1'b0;
  logic reset;
  logic signed [WIDTH-1:0] input_data  [SIZE];
  logic signed [WIDTH-1:0] output_data [SIZE];

  int compared   = 0;
  int mismatched = 0;

  // Expected outputs are sigmoid(x) rounded to 10 fractional bits, then shifted left by 2 into Q4.12.
  logic [15:0] vin  [8] = '{16'h1000, 16'hF000, 16'hC000, 16'h4000,
                            16'h0000, 16'h2000, 16'h8000, 16'h7FFF};
  logic [15:0] vexp [8] = '{16'h0BB4, 16'h044C, 16'h0048, 16'h0FB8,
                            16'h0800, 16'h0E18, 16'h0000, 16'h0FFC};

  always #5 clk = ~clk;

  activation_layer #(
    .WIDTH         (WIDTH),
    .NFRAC         (NFRAC),
    .SIZE          (SIZE),
    .MEM_WIDTH     (MEM_WIDTH),
    .TABLE_SIZE_POW(TABLE_SIZE_POW),
    .BRAM_FILE     ("memw10_size1024_sigmoidBRAM.mem")
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .input_data (input_data),
    .output_data(output_data)
  );

  task automatic test_reset();
    reset = 1'b0;
    for (int l = 0; l < SIZE; l++) input_data[l] = 16'(16'h5A00 + l);
    repeat (2) @(posedge clk);
    #1;
    for (int l = 0; l < SIZE; l++) begin
      compared++;
      if (output_data[l] !== 16'h0000) begin
        mismatched++;
        $display("[TB] FAIL reset_hold lane %0d: got 0x%04h expected 0x0000", l, output_data[l]);
      end
    end
    for (int l = 0; l < SIZE; l++) input_data[l] = 16'(l);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    for (int l = 0; l < SIZE; l++) begin
      compared++;
      if (output_data[l] !== 16'h0000) begin
        mismatched++;
        $display("[TB] FAIL reset_first_edge lane %0d: got 0x%04h expected 0x0000", l, output_data[l]);
      end
    end
    @(posedge clk); #1;
    for (int l = 0; l < SIZE; l++) begin
      compared++;
      if (output_data[l] !== 16'h0800) begin
        mismatched++;
        $display("[TB] FAIL reset_second_edge lane %0d: got 0x%04h expected 0x0800", l, output_data[l]);
      end
    end
  endtask

  task automatic test_function();
    int offs [2] = '{0, 5};
    for (int p = 0; p < 2; p++) begin
      for (int l = 0; l < SIZE; l++) input_data[l] = vin[(l + offs[p]) % 8];
      repeat (2) @(posedge clk);
      #1;
      for (int l = 0; l < SIZE; l++) begin
        compared++;
        if (output_data[l] !== vexp[(l + offs[p]) % 8]) begin
          mismatched++;
          $display("[TB] FAIL lookup in=0x%04h lane %0d: got 0x%04h expected 0x%04h",
                   vin[(l + offs[p]) % 8], l, output_data[l], vexp[(l + offs[p]) % 8]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] sin  [4] = '{16'h8000, 16'h7FFF, 16'h8001, 16'h7FFE};
    logic [15:0] sexp [4] = '{16'h0000, 16'h0FFC, 16'h0000, 16'h0FFC};
    for (int l = 0; l < SIZE; l++) input_data[l] = sin[l % 4];
    repeat (2) @(posedge clk);
    #1;
    for (int l = 0; l < SIZE; l++) begin
      compared++;
      if (output_data[l] !== sexp[l % 4]) begin
        mismatched++;
        $display("[TB] FAIL saturate in=0x%04h lane %0d: got 0x%04h expected 0x%04h",
                 sin[l % 4], l, output_data[l], sexp[l % 4]);
      end
    end
  endtask

  task automatic test_rounding();
    logic [15:0] rin  [4] = '{16'h0020, 16'hFFE0, 16'h1000, 16'h7FFF};
`ifdef ACTIVATION_LAYER_ROUND_EN
    logic [15:0] rexp [4] = '{16'h0810, 16'h0800, 16'h0BB4, 16'h0FFC};
`else
    logic [15:0] rexp [4] = '{16'h0800, 16'h07F0, 16'h0BB4, 16'h0FFC};
`endif
    for (int l = 0; l < SIZE; l++) input_data[l] = rin[l % 4];
    repeat (2) @(posedge clk);
    #1;
    for (int l = 0; l < SIZE; l++) begin
      compared++;
      if (output_data[l] !== rexp[l % 4]) begin
        mismatched++;
        $display("[TB] FAIL rounding in=0x%04h lane %0d: got 0x%04h expected 0x%04h",
                 rin[l % 4], l, output_data[l], rexp[l % 4]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c <= 8; c++) begin
      if (c < 8) begin
        for (int l = 0; l < SIZE; l++) input_data[l] = vin[(c + l) % 8];
      end
      @(posedge clk); #1;
      if (c >= 1) begin
        for (int l = 0; l < SIZE; l++) begin
          compared++;
          if (output_data[l] !== vexp[(c - 1 + l) % 8]) begin
            mismatched++;
            $display("[TB] FAIL stream cycle %0d lane %0d: got 0x%04h expected 0x%04h",
                     c, l, output_data[l], vexp[(c - 1 + l) % 8]);
          end
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int l = 0; l < SIZE; l++) input_data[l] = 16'h1000;
    repeat (3) @(posedge clk);
    #1;
    for (int l = 0; l < SIZE; l++) begin
      compared++;
      if (output_data[l] !== 16'h0BB4) begin
        mismatched++;
        $display("[TB] FAIL pre_pulse lane %0d: got 0x%04h expected 0x0BB4", l, output_data[l]);
      end
    end
    for (int l = 0; l < SIZE; l++) input_data[l] = 16'h4000;
    #1 reset = 1'b0;
    #1;
    for (int l = 0; l < SIZE; l++) begin
      compared++;
      if (output_data[l] !== 16'h0000) begin
        mismatched++;
        $display("[TB] FAIL pulse_async lane %0d: got 0x%04h expected 0x0000", l, output_data[l]);
      end
    end
    #1 reset = 1'b1;
    @(posedge clk); #1;
    for (int l = 0; l < SIZE; l++) begin
      compared++;
      if (output_data[l] !== 16'h0000) begin
        mismatched++;
        $display("[TB] FAIL pulse_discard lane %0d: got 0x%04h expected 0x0000", l, output_data[l]);
      end
    end
    @(posedge clk); #1;
    for (int l = 0; l < SIZE; l++) begin
      compared++;
      if (output_data[l] !== 16'h0FB8) begin
        mismatched++;
        $display("[TB] FAIL pulse_resume lane %0d: got 0x%04h expected 0x0FB8", l, output_data[l]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_function();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
